// File: rtl/hash_loop_ctrl.sv
// Loop sequencer for the iterated hash round engine: checks a job's loop count
// against a programmable limit and issues one round_go per iteration.
// Optional per-round watchdog: define HASH_LOOP_WDOG_EN.
//
// Handshake: round_go is a one-cycle pulse that launches exactly one round;
// the datapath answers with a one-cycle round_ready pulse. Only one round is
// outstanding at any time, and round_ready is honoured only in WAIT and DRAIN.
module hash_loop_ctrl #(
    parameter int              CNT_W     = 16,
    parameter logic [CNT_W-1:0] LIMIT_RST = 16'd5000,
    parameter int              WDOG_CYC  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             limit_we,
    input  logic [CNT_W-1:0] limit_din,
    input  logic             start,
    input  logic [CNT_W-1:0] loop_target,
    input  logic             stop,
    output logic             round_go,
    input  logic             round_ready,
    output logic [CNT_W-1:0] current_loop,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] loop_next;
    logic             wdog_fire;

    assign loop_next = current_loop + CNT_W'(1);
    assign state_dbg = state;

`ifdef HASH_LOOP_WDOG_EN
    localparam int               WD_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wdog_cnt;

    // Counts cycles spent waiting for the current round; zero again whenever
    // the FSM passes through ISSUE, i.e. on every round_go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if (state == S_WAIT || state == S_DRAIN) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_fire = (state == S_WAIT || state == S_DRAIN) && (wdog_cnt == WD_LAST);
`else
    assign wdog_fire = 1'b0;
`endif

    // The limit only moves between jobs so a running job sees a stable policy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit <= LIMIT_RST;
        end else if (state == S_IDLE && limit_we) begin
            limit <= limit_din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            target       <= '0;
            current_loop <= '0;
            round_go     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
        end else begin
            round_go <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        target       <= loop_target;
                        current_loop <= '0;
                        fail         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (target > limit) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (target == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end

                // round_go is launched on leaving ISSUE so a stop seen here
                // can still suppress it.
                S_ISSUE: begin
                    if (stop) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        round_go <= 1'b1;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (round_ready) begin
                        current_loop <= loop_next;
                        if (stop) begin
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (loop_next == target) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (wdog_fire) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (stop) begin
                        state <= S_DRAIN;
                    end
                end

                // A round is still in flight; let it land before failing.
                S_DRAIN: begin
                    if (round_ready) begin
                        current_loop <= loop_next;
                        fail         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (wdog_fire) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_loop_ctrl.sv
// Directed bench for hash_loop_ctrl: limit policy, full jobs, stop/drain,
// stop-vs-completion race, idle round_ready and asynchronous reset mid-job.
module tb_hash_loop_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             limit_we = 1'b0;
  logic [CNT_W-1:0] limit_din = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] loop_target = '0;
  logic             stop = 1'b0;
  logic             round_go;
  logic             round_ready = 1'b0;
  logic [CNT_W-1:0] current_loop;
  logic             busy;
  logic             done;
  logic             fail;
  logic [2:0]       state_dbg;

  int total = 0;
  int bad = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  logic auto_ack = 1'b0;
  logic go_seen = 1'b0;
  logic [31:0] exp_q[$];

  hash_loop_ctrl dut (
    .clk(clk),
    .reset(reset),
    .limit_we(limit_we),
    .limit_din(limit_din),
    .start(start),
    .loop_target(loop_target),
    .stop(stop),
    .round_go(round_go),
    .round_ready(round_ready),
    .current_loop(current_loop),
    .busy(busy),
    .done(done),
    .fail(fail),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // pulse monitor
  always @(negedge clk) begin
    if (round_go) go_cnt++;
    if (done) done_cnt++;
  end

  // datapath model: acks one cycle after round_go when auto_ack is set,
  // and retires any manual round_ready pulse after one cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      round_ready = auto_ack & go_seen;
      go_seen = round_go;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_mon();
    @(posedge clk);
    #1;
    go_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic write_limit(input int v);
    @(negedge clk);
    limit_we = 1'b1;
    limit_din = CNT_W'(v);
    @(negedge clk);
    limit_we = 1'b0;
  endtask

  // returns at the negedge of the CHECK cycle
  task automatic start_job(input int tgt);
    @(negedge clk);
    loop_target = CNT_W'(tgt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // advances to the next negedge where round_go is high
  task automatic wait_go(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!round_go && n < 50);
    check(tag, 32'(round_go), 32'd1);
  endtask

  initial begin
    // reset release, nothing started
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_round_go", 32'(round_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_loop", 32'(current_loop), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // target equal to limit (5000) accepted; first round_go two cycles after CHECK
    write_limit(5000);
    clear_mon();
    start_job(5000);
    check("lim_busy_check", 32'(busy), 32'd1);
    @(negedge clk);
    check("lim_issue_no_go", 32'(round_go), 32'd0);
    @(negedge clk);
    check("lim_first_go", 32'(round_go), 32'd1);
    check("lim_fail_low", 32'(fail), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    check("lim_drain_state", 32'(state_dbg), 32'd4);
    round_ready = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("lim_abort_fail", 32'(fail), 32'd1);
    check("lim_abort_loop", 32'(current_loop), 32'd1);
    check("lim_abort_busy", 32'(busy), 32'd0);

    // full 120-round job, ack one cycle after each round_go
    auto_ack = 1'b1;
    clear_mon();
    exp_q.push_back(32'd120);
    start_job(120);
    check("j120_fail_cleared", 32'(fail), 32'd0);
    wait_idle("j120_idle", 1000);
    check("j120_go_count", 32'(go_cnt), exp_q.pop_front());
    check("j120_loop", 32'(current_loop), 32'd120);
    check("j120_done_count", 32'(done_cnt), 32'd1);
    check("j120_fail", 32'(fail), 32'd0);

    // round_ready in IDLE leaves the counter alone
    @(negedge clk);
    round_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_ignored", 32'(current_loop), 32'd120);

    // over-limit request rejected, then a good job clears fail
    clear_mon();
    start_job(5010);
    check("over_fail_not_yet", 32'(fail), 32'd0);
    @(negedge clk);
    check("over_fail", 32'(fail), 32'd1);
    check("over_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("over_no_go", 32'(go_cnt), 32'd0);

    clear_mon();
    exp_q.push_back(32'd456);
    start_job(456);
    check("j456_fail_cleared", 32'(fail), 32'd0);
    wait_idle("j456_idle", 3000);
    check("j456_go_count", 32'(go_cnt), exp_q.pop_front());
    check("j456_loop", 32'(current_loop), 32'd456);
    check("j456_done_count", 32'(done_cnt), 32'd1);
    check("j456_fail", 32'(fail), 32'd0);

    // zero-length job goes straight to done
    clear_mon();
    exp_q.push_back(32'd0);
    start_job(0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd1);
    wait_idle("zero_idle", 10);
    check("zero_go_count", 32'(go_cnt), exp_q.pop_front());
    check("zero_loop", 32'(current_loop), 32'd0);

    // stop after round 7's round_go: drain, count the ack, fail
    auto_ack = 1'b0;
    write_limit(8000);
    clear_mon();
    start_job(8000);
    for (int r = 1; r <= 7; r++) begin
      wait_go("stop7_go");
      if (r < 7) round_ready = 1'b1;
    end
    stop = 1'b1;
    @(negedge clk);
    check("stop7_drain_state", 32'(state_dbg), 32'd4);
    repeat (3) @(negedge clk);
    check("stop7_still_busy", 32'(busy), 32'd1);
    round_ready = 1'b1;
    @(negedge clk);
    check("stop7_loop", 32'(current_loop), 32'd7);
    check("stop7_fail", 32'(fail), 32'd1);
    check("stop7_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    repeat (4) @(negedge clk);
    check("stop7_go_count", 32'(go_cnt), 32'd7);
    check("stop7_done_count", 32'(done_cnt), 32'd0);

    // stop and round_ready together on the final round: stop wins
    clear_mon();
    start_job(3);
    for (int r = 1; r <= 3; r++) begin
      wait_go("race_go");
      if (r == 3) stop = 1'b1;
      round_ready = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    check("race_loop", 32'(current_loop), 32'd3);
    check("race_fail", 32'(fail), 32'd1);
    check("race_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("race_no_done", 32'(done_cnt), 32'd0);

    // asynchronous reset in the middle of a 1000-round job
    auto_ack = 1'b1;
    clear_mon();
    start_job(1000);
    begin
      int n = 0;
      while (current_loop != CNT_W'(10) && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_reached_10", 32'(current_loop), 32'd10);
    auto_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_loop", 32'(current_loop), 32'd0);
    check("mid_go", 32'(round_go), 32'd0);
    check("mid_fail", 32'(fail), 32'd0);
    check("mid_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_no_done", 32'(done_cnt), 32'd0);
    check("mid_no_fail", 32'(fail), 32'd0);

    // limit back to 5000 after reset: 5001 rejected
    start_job(5001);
    @(negedge clk);
    check("rst_limit_reject", 32'(fail), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_loop_ctrl.md
Name: hash_loop_ctrl

Overview:
Sequencer for the iterated hash datapath. It accepts a job with a requested loop count and checks that count against a programmable loop limit. It issues one round-go pulse per iteration to the hash round engine and tracks the live loop counter. It reports done, or fail on limit violation or stop. It sits between the host/job interface and the hash round datapath, and owns the loop-limit policy.

Parameters:
CNT_W, 16, width of loop counter, target and limit
LIMIT_RST, 16'd5000, loop limit after reset
WDOG_CYC, 64, watchdog cycles per round (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
limit_we  in  1  write enable for loop limit register
limit_din  in  CNT_W  new loop limit
start  in  1  job request, sampled only in IDLE
loop_target  in  CNT_W  requested iteration count, captured with start
stop  in  1  abort request, level-sampled
round_go  out  1  one-cycle pulse: datapath starts one round
round_ready  in  1  one-cycle pulse: datapath finished the round
current_loop  out  CNT_W  completed-round count of the active job
busy  out  1  job in progress
done  out  1  one-cycle pulse, job completed all rounds
fail  out  1  sticky failure flag, cleared on next accepted start

Behaviour:
- Reset (reset=0, async): state=IDLE, limit=LIMIT_RST, target=0, current_loop=0, round_go=0, busy=0, done=0, fail=0.
- All outputs registered. Every state change occurs on a clk rising edge.
- limit_we writes take effect in IDLE only; ignored while busy.
- States: IDLE, CHECK, ISSUE, WAIT, DRAIN, DONE.
- IDLE: busy=0. If start=1: capture loop_target, clear current_loop and fail, then go to CHECK (busy=1 next cycle).
- CHECK:
  - target > limit: fail=1, go to IDLE. Limit equal to target is allowed.
  - target == 0: go to DONE.
  - otherwise go to ISSUE.
- ISSUE: round_go=1 for exactly one cycle, then go to WAIT. If stop=1 in ISSUE, suppress round_go, set fail=1, go to IDLE.
- WAIT: on round_ready, current_loop increments by 1.
  - If the new value == target, go to DONE; otherwise go to ISSUE.
  - Next round_go therefore comes 2 cycles after round_ready.
  - If stop=1 and round_ready=0, go to DRAIN.
  - If stop and round_ready occur in the same cycle, the round counts, then fail=1 and go to IDLE. This applies even if it was the last round: stop wins over completion.
- DRAIN: wait for the outstanding round_ready, increment current_loop, set fail=1, go to IDLE. round_go is never issued in DRAIN.
- DONE: done=1 for one cycle, then IDLE. current_loop holds its final value until the next start.
- round_ready outside WAIT/DRAIN is ignored; it does not change the counter.
- current_loop never exceeds target, so there is no wrap-around.
- Minimum job latency: start to done = 3 + N*(round latency + 2) cycles.
- Reset asserted mid-job: immediate return to reset values. No done or fail is produced.

Optional Feature:
HASH_LOOP_WDOG_EN
- Defined: a per-round cycle counter runs in WAIT and DRAIN and clears on each round_go. If it reaches WDOG_CYC without round_ready, fail=1 and go to IDLE; a late round_ready is ignored.
- Undefined: no watchdog logic; the block waits indefinitely in WAIT/DRAIN. WDOG_CYC is unused.

Test Plan:
- Reset release, no start -> all outputs 0, limit reads back 5000 (write via limit_we, verify a target of 5000 is accepted).
- start with target=120, datapath acks 1 cycle after each round_go -> 120 round_go pulses, current_loop=120, single done pulse, fail=0.
- start with target=5010, limit=5000 -> no round_go, fail=1 within 2 cycles, busy drops; then start with target=456 clears fail and completes with done.
- target=8000, limit_we=1 with limit_din=8000; stop=1 after round 7's round_go -> DRAIN, current_loop=7 after ack, fail=1, no further round_go.
- target=3, stop and round_ready on the same cycle of the third round -> current_loop=3, fail=1, no done.
- Reset pulsed mid-job (target=1000, current_loop=10) -> outputs cleared asynchronously, no done/fail. With HASH_LOOP_WDOG_EN: withhold round_ready -> fail=1 exactly WDOG_CYC cycles after round_go.
